imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate-extension stage for the 32-bit MIPS datapath, placed between the decode register and the ALU operand mux. It widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI), or branch offset (sign-extend, then shift left 2). A valid/ready handshake lets a stalled execute stage back-pressure decode without losing or duplicating immediates. A tag field carries per-beat sideband data, for example the destination register, alongside each result.

---
 rtl/imm_extend_pipe.sv | 143 ++++++++++++++
 tb/tb_imm_extend_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign / zero / upper / branch) with valid-ready handshake.
// Define IMM_EXT_SKID_EN to add a skid register and a registered in_ready.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_mode
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_data;
  logic             accept;
  logic             drain;

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic [1:0]       main_mode_q, main_mode_d;

  always_comb begin
    sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    case (in_mode)
      2'b00:   ext_data = sext;
      2'b01:   ext_data = {{PAD_W{1'b0}}, in_imm};
      2'b10:   ext_data = {in_imm, {PAD_W{1'b0}}};
      default: ext_data = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  assign accept = in_valid && in_ready;
  assign drain  = main_valid_q && out_ready;

`ifdef IMM_EXT_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic [1:0]       skid_mode_q, skid_mode_d;

  // Skid is only ever occupied behind a full main, so "skid empty" is the ready.
  assign in_ready = !skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    main_mode_d  = main_mode_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    skid_mode_d  = skid_mode_q;
    if (drain) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_tag_d   = skid_tag_q;
        main_mode_d  = skid_mode_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
    // Post-drain occupancy decides where the new beat lands, preserving order.
    if (accept) begin
      if (!main_valid_d) begin
        main_valid_d = 1'b1;
        main_data_d  = ext_data;
        main_tag_d   = in_tag;
        main_mode_d  = in_mode;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = ext_data;
        skid_tag_d   = in_tag;
        skid_mode_d  = in_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      skid_mode_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      skid_mode_q  <= skid_mode_d;
    end
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    main_mode_d  = main_mode_q;
    if (drain) begin
      main_valid_d = 1'b0;
    end
    if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = ext_data;
      main_tag_d   = in_tag;
      main_mode_d  = in_mode;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      main_mode_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      main_mode_q  <= main_mode_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_tag   = main_tag_q;
  assign out_mode  = main_mode_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed cases plus randomized traffic against a queue model.
// Expectations follow IMM_EXT_SKID_EN when it is defined.
module tb_imm_extend_pipe;

`ifdef IMM_EXT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode, out_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  logic        w_valid, w_ready, w_ovalid, w_ordy;
  logic [11:0] w_imm;
  logic [1:0]  w_mode, w_omode;
  logic [4:0]  w_tag, w_otag;
  logic [19:0] w_odata;

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_mode(out_mode)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(5)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .in_valid(w_valid), .in_ready(w_ready), .in_imm(w_imm), .in_mode(w_mode), .in_tag(w_tag),
    .out_valid(w_ovalid), .out_ready(w_ordy), .out_data(w_odata), .out_tag(w_otag),
    .out_mode(w_omode)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic [1:0]  mode;
  } beat_t;

  beat_t      q[$];
  int         checks = 0;
  int         errors = 0;
  int         acc_cnt = 0;
  logic       last_acc, last_drn;
  logic [4:0] dut_drn_tag;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Arithmetic view of the four modes: signed value, scaled, reduced mod 2^out_w.
  function automatic logic [63:0] ref_ext(input int in_w, input int out_w, input longint imm,
                                          input int mode);
    longint m = (64'sd1 <<< out_w) - 1;
    longint s = (imm >= (64'sd1 <<< (in_w - 1))) ? imm - (64'sd1 <<< in_w) : imm;
    case (mode)
      0:       return s & m;
      1:       return imm;
      2:       return (imm * (64'sd1 <<< (out_w - in_w))) & m;
      default: return (s * 4) & m;
    endcase
  endfunction

  function automatic logic exp_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || (out_ready === 1'b1);
  endfunction

  task automatic step(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, input logic ordy);
    beat_t       b;
    logic [63:0] r;
    @(negedge clk);
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    in_tag    = tag;
    out_ready = ordy;
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, exp_ready());
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_tag", out_tag, q[0].tag);
      chk("out_mode", out_mode, q[0].mode);
    end
    last_drn = (q.size() > 0) && ordy;
    last_acc = v && exp_ready();
    if (last_drn) begin
      dut_drn_tag = out_tag;
      void'(q.pop_front());
    end
    if (last_acc) begin
      acc_cnt++;
      r = ref_ext(16, 32, longint'(imm), int'(mode));
      b.data = r[31:0];
      b.tag  = tag;
      b.mode = mode;
      q.push_back(b);
    end
  endtask

  logic [31:0] mexp[4];
  int p, acc_stall, ndrn, cyc;

  initial begin
    mexp[0] = 32'hFFFF8004;
    mexp[1] = 32'h00008004;
    mexp[2] = 32'h80040000;
    mexp[3] = 32'hFFFE0010;
    reset_n = 1'b0;
    in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
    w_valid = 1'b0; w_imm = '0; w_mode = '0; w_tag = '0; w_ordy = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_mode", out_mode, 0);
    step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_w_ready", w_ready, 1);

    // Narrow instance: 12-bit 0x800 in branch mode
    @(negedge clk);
    w_valid = 1'b1; w_imm = 12'h800; w_mode = 2'd3; w_tag = 5'd9; w_ordy = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    #1;
    chk("w_out_valid", w_ovalid, 1);
    chk("w_out_data", w_odata, 20'hFE000);
    chk("w_out_tag", w_otag, 9);

    for (int i = 0; i < 5; i++) begin
      step(i < 4, 16'h8004, 2'(i), 5'(i + 1), 1'b1);
      if (i > 0) begin
        chk("mode_const_data", out_data, mexp[i-1]);
        chk("mode_const_tag", out_tag, i);
      end
    end

    step(1'b1, 16'h7FFF, 2'd0, 5'd10, 1'b1);
    step(1'b1, 16'h7FFF, 2'd3, 5'd11, 1'b1);
    chk("pos_sign", out_data, 32'h00007FFF);
    step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);
    chk("pos_branch", out_data, 32'h0001FFFC);

    for (int k = 0; k < 8; k++) begin
      step(1'b1, (k < 4) ? 16'h0000 : 16'hFFFF, 2'(k), 5'(k + 12), 1'b1);
    end
    step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);

    // Back-pressure: tags 1..6, consumer stalled for 4 cycles
    p = 1; acc_stall = 0; ndrn = 0;
    for (int c = 0; c < 20 && ndrn < 6; c++) begin
      step(p <= 6, 16'($urandom), 2'($urandom), 5'(p), c >= 4);
      if (c == 2) chk("bp_ready_stalled", in_ready, 0);
      if (c == 4) chk("bp_ready_release", in_ready, SKID ? 0 : 1);
      if (last_acc) begin
        p++;
        if (c < 4) acc_stall++;
      end
      if (last_drn) begin
        chk("bp_order", dut_drn_tag, ndrn + 1);
        chk("bp_no_gap", c, ndrn + 4);
        ndrn++;
      end
    end
    chk("bp_accepted_stalled", acc_stall, SKID ? 2 : 1);
    chk("bp_drained", ndrn, 6);

    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 10000 && cyc < 50000) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), 5'($urandom),
           1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_beats", acc_cnt, 10000);
    for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);
    chk("rand_empty", out_valid, 0);

    // Reset while beats are held
    step(1'b1, 16'h1234, 2'd0, 5'd7, 1'b0);
    step(1'b1, 16'h4321, 2'd1, 5'd8, 1'b0);
    step(1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    chk("pre_rst_held", out_valid, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_tag", out_tag, 0);
    chk("async_rst_data", out_data, 0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);
      chk("post_rst_tag", out_tag, 0);
    end
    step(1'b1, 16'hABCD, 2'd2, 5'd21, 1'b1);
    step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1);
    chk("post_rst_beat", out_data, 32'hABCD0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
